// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed flop-array data memory, async clear, optional registered read.
// Build option: define DMEM_REG_READ_EN for one-cycle registered read latency.
module data_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              We,
    output logic [DATA_W-1:0] Data_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;

    // Full-width compare so upper address bits never alias onto low words.
    assign w_in_range = (Addr < ADDR_W'(DEPTH));
    assign w_idx      = Addr[IDX_W-1:0];
    assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (We && w_in_range) begin
            r_mem[w_idx] <= Data_in;
        end
    end

`ifdef DMEM_REG_READ_EN
    logic [DATA_W-1:0] r_data_out;

    // Samples the pre-write contents when a same-address write lands on this edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rd_data;
        end
    end

    assign Data_out = r_data_out;
`else
    assign Data_out = Rst ? '0 : w_rd_data;
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - randomized self-checking bench for data_memory against an array reference model.
module tb_data_memory;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;

    logic              Clk;
    logic              Rst;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Data_in;
    logic              We;
    logic [DATA_W-1:0] Data_out;

    int n_checks;
    int n_fails;

    logic [DATA_W-1:0] ref_mem [DEPTH];

    data_memory #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Addr     (Addr),
        .Data_in  (Data_in),
        .We       (We),
        .Data_out (Data_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (Addr=0x%08h t=%0t)", tag, got, exp, Addr, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (a < DEPTH) return ref_mem[a[7:0]];
        return '0;
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endfunction

    // One full clock cycle, entered and left just after a falling edge.
    task automatic do_cycle(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic w);
        logic [DATA_W-1:0] exp_pre;
        Addr    = a;
        Data_in = d;
        We      = w;
        #1;
        exp_pre = ref_read(a);
`ifndef DMEM_REG_READ_EN
        check_eq("rd_pre_edge", Data_out, exp_pre);
`endif
        @(posedge Clk);
        if (w && (a < DEPTH) && !Rst) ref_mem[a[7:0]] = d;
        #1;
`ifdef DMEM_REG_READ_EN
        check_eq("rd_reg", Data_out, exp_pre);
`else
        check_eq("rd_post_edge", Data_out, ref_read(a));
`endif
        @(negedge Clk);
    endtask

    // Reset pulse placed strictly between rising edges.
    task automatic reset_pulse();
        #2;
        Rst = 1'b1;
        #1;
        check_eq("rst_async_out", Data_out, '0);
        ref_clear();
        #1;
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        n_checks = 0;
        n_fails  = 0;
        Rst      = 1'b1;
        Addr     = '0;
        Data_in  = '0;
        We       = 1'b0;
        ref_clear();

        // Reset held: output zero at every address, immediately.
        #12;
        for (int i = 0; i < 5; i++) begin
            Addr = ADDR_W'(i);
            #1;
            check_eq("rst_hold_read", Data_out, '0);
        end
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) do_cycle(ADDR_W'(i), '0, 1'b0);

        // Write sweep and read-back.
        for (int i = 0; i < 5; i++) do_cycle(ADDR_W'(i), 32'd34000, 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(ADDR_W'(i), '0, 1'b0);
        do_cycle(32'd5, '0, 1'b0);
        do_cycle(32'd5, '0, 1'b0);

        // No write when We=0.
        for (int i = 0; i < 5; i++) do_cycle(32'd2, 32'hDEADBEEF, 1'b0);
        do_cycle(32'd2, '0, 1'b0);
        check_eq("no_write_addr2", Data_out, 32'd34000);

        // Read-during-write, then hold We at one address.
        do_cycle(32'd7, 32'h12345678, 1'b1);
        do_cycle(32'd7, '0, 1'b0);
        check_eq("rdw_addr7", Data_out, 32'h12345678);
        for (int i = 0; i < 4; i++) do_cycle(32'd9, 32'hA000_0000 + i, 1'b1);
        do_cycle(32'd9, '0, 1'b0);
        check_eq("last_write_wins", Data_out, 32'hA000_0003);

        // Out-of-range writes ignored, no aliasing onto low words.
        do_cycle(32'd256, 32'hFFFFFFFF, 1'b1);
        do_cycle(32'd256, '0, 1'b0);
        check_eq("oor_read_256", Data_out, '0);
        do_cycle(32'h8000_0000, 32'hFFFFFFFF, 1'b1);
        do_cycle(32'h0000_0300, 32'hFFFFFFFF, 1'b1);
        do_cycle(32'd0, '0, 1'b0);
        do_cycle(32'd0, '0, 1'b0);
        check_eq("no_alias_addr0", Data_out, 32'd34000);

        // Mid-operation reset clears the array.
        reset_pulse();
        for (int i = 0; i < 10; i++) do_cycle(ADDR_W'(i), '0, 1'b0);

        // Write attempted across an edge with Rst high is blocked.
        Rst = 1'b1;
        ref_clear();
        Addr = 32'd3; Data_in = 32'h5555AAAA; We = 1'b1;
        @(posedge Clk);
        #1;
        check_eq("rst_blocks_write_out", Data_out, '0);
        @(negedge Clk);
        Rst = 1'b0;
        do_cycle(32'd3, '0, 1'b0);
        do_cycle(32'd3, '0, 1'b0);
        check_eq("rst_blocks_write_mem", Data_out, '0);

        // Randomized traffic with occasional far addresses and reset pulses.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = ADDR_W'($urandom_range(0, 7)) << $urandom_range(8, 31);
                2:       a = ADDR_W'($urandom_range(250, 262));
                default: a = ADDR_W'($urandom_range(0, 31));
            endcase
            d = $urandom;
            if ($urandom_range(0, 99) == 0) reset_pulse();
            do_cycle(a, d, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-addressed data memory for the single-cycle MIPS datapath, sitting behind the ALU address output in the MEM stage.
- Writes are synchronous (rising Clk, We=1); reads are asynchronous/combinational by default.
- Asynchronous active-high reset clears every word to zero.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, width of the Addr port.
- DEPTH, 256, number of words implemented; valid word indices are 0..DEPTH-1.

Ports:
- Clk  input  1  system clock; all writes occur on its rising edge.
- Rst  input  1  asynchronous, active-high reset; clears the whole array.
- Addr  input  ADDR_W  word address (index, not byte address); Addr=1 selects the second 32-bit word.
- Data_in  input  DATA_W  write data.
- We  input  1  write enable, sampled on rising Clk.
- Data_out  output  DATA_W  read data for the word at Addr.

Behaviour:
- Storage: DEPTH x DATA_W register array, implemented as flops so reset can clear it.
- Reset:
  - Rst=1 asynchronously forces every word to 0, independent of Clk.
  - Data_out reads 0 for any address while Rst=1 and after reset until a write occurs.
  - Writes are blocked while Rst=1.
- Write:
  - On rising Clk with Rst=0, We=1 and Addr<DEPTH: mem[Addr] <= Data_in.
  - We=0: no change.
- Read (default):
  - Data_out = mem[Addr] combinationally, with zero latency.
  - Changing Addr updates Data_out in the same cycle.
- Read-during-write, same address:
  - Before the edge, Data_out shows the old contents.
  - After the edge, it shows Data_in; no bypass of Data_in onto Data_out.
- Out of range (Addr >= DEPTH):
  - Writes are ignored.
  - Reads return 0.
  - Upper address bits must not alias.
- Data_in is passed through unmodified: full DATA_W, no sign extension or byte lanes.
- Holding We=1 across several cycles at one address rewrites that word each edge; the last value wins.
- No X propagation: Data_out is always a defined value after reset.

Optional Feature:
- Macro DMEM_REG_READ_EN.
- Defined:
  - Data_out is registered, giving one-cycle read latency: on rising Clk, Data_out <= mem[Addr] (the pre-write value when a write to the same address happens on that edge).
  - Out-of-range reads register 0.
  - Rst clears the Data_out register asynchronously to 0.
- Undefined: combinational read as described above.

Test Plan:
- Reset: assert Rst=1 mid-cycle -> Data_out=0 immediately at Addr 0..4. Release Rst, We=0, sweep Addr 0..4 -> all reads 0.
- Write sweep: We=1, Data_in=34000, Addr 0,1,2,3,4 across edges -> after each edge Data_out=34000 at that Addr. Then We=0, re-read 0..4 -> all 34000. Addr 5 still reads 0.
- No-write check: We=0, Data_in=0xDEADBEEF, Addr=2 over 5 edges -> Data_out stays 34000.
- Read-during-write: Addr=7, We=1, Data_in=0x12345678 -> Data_out=0 before the edge, 0x12345678 after; with DMEM_REG_READ_EN, 0x12345678 appears one edge later.
- Out of range: We=1, Addr=DEPTH (256), Data_in=0xFFFFFFFF -> Data_out=0. Addr=0 still reads 34000, confirming no aliasing.
- Reset mid-operation: after the writes above, pulse Rst between edges -> all words read 0. A write attempted in a cycle with Rst high leaves the word at 0.
